cpu_ctrl_fsm: RTL and testbench

- Control sequencer for the 16-bit single-bus processor datapath: the register file R0-R7, the A/G accumulator ALU with its add/subtract unit, and the shared buswires.
- Fetches a 9-bit instruction word from din into an internal instruction register (IR).
- Decodes IR and steps through time slots T0-T3, driving one-hot register-in/register-out strobes, ain, gin, sub, gout, dinout and done.
- Sits beside the ALU and register file; its strobes feed the bus mux and the load enables of each register.

---
 rtl/cpu_ctrl_fsm.sv | 134 +++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Control sequencer for the single-bus processor: fetches a 9-bit instruction into IR and
// steps T0-T3 driving bus/load strobes. Optional mvnz opcode via CPU_CTRL_MVNZ_EN.
module cpu_ctrl_fsm #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int IR_WIDTH   = 9
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  g_nz,
  output logic                  irin,
  output logic [NUM_REGS-1:0]   rin,
  output logic [NUM_REGS-1:0]   rout,
  output logic                  gout,
  output logic                  dinout,
  output logic                  ain,
  output logic                  gin,
  output logic                  sub,
  output logic                  done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IR_WIDTH-1:0] r_ir;
  logic [2:0]          w_op;
  logic [2:0]          w_x;
  logic [2:0]          w_y;
  logic [NUM_REGS-1:0] w_x_sel;
  logic [NUM_REGS-1:0] w_y_sel;

  assign w_op    = r_ir[IR_WIDTH-1 -: 3];
  assign w_x     = r_ir[5:3];
  assign w_y     = r_ir[2:0];
  assign w_x_sel = NUM_REGS'(1) << w_x;
  assign w_y_sel = NUM_REGS'(1) << w_y;

`ifdef CPU_CTRL_MVNZ_EN
  logic w_unused;
  assign w_unused = ^din[DATA_WIDTH-1:IR_WIDTH];
`else
  logic w_unused;
  assign w_unused = ^{din[DATA_WIDTH-1:IR_WIDTH], g_nz};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == T0 && run) begin
        r_ir <= din[IR_WIDTH-1:0];
      end
    end
  end

  // Outputs are purely decoded from state/IR/run, so reset clears them asynchronously.
  always_comb begin
    w_next = r_state;
    irin   = 1'b0;
    rin    = '0;
    rout   = '0;
    gout   = 1'b0;
    dinout = 1'b0;
    ain    = 1'b0;
    gin    = 1'b0;
    sub    = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      T0: begin
        irin   = run;
        w_next = run ? T1 : T0;
      end
      T1: begin
        case (w_op)
          3'b000: begin
            rout   = w_y_sel;
            rin    = w_x_sel;
            done   = 1'b1;
            w_next = T0;
          end
          3'b001: begin
            dinout = 1'b1;
            rin    = w_x_sel;
            done   = 1'b1;
            w_next = T0;
          end
          3'b010, 3'b011: begin
            rout   = w_x_sel;
            ain    = 1'b1;
            w_next = T2;
          end
`ifdef CPU_CTRL_MVNZ_EN
          3'b100: begin
            if (g_nz) begin
              rout = w_y_sel;
              rin  = w_x_sel;
            end
            done   = 1'b1;
            w_next = T0;
          end
`endif
          default: begin
            done   = 1'b1;
            w_next = T0;
          end
        endcase
      end
      T2: begin
        rout   = w_y_sel;
        gin    = 1'b1;
        sub    = r_ir[6];
        w_next = T3;
      end
      T3: begin
        gout   = 1'b1;
        rin    = w_x_sel;
        done   = 1'b1;
        w_next = T0;
      end
      default: w_next = T0;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: per-cycle expectation queue from an instruction-level
// model, literal spot checks, reset abort, and a random instruction stream.
module tb_cpu_ctrl_fsm;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       gout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       sub;
    logic       done;
  } outs_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        g_nz;
  logic        irin, gout, dinout, ain, gin, sub, done;
  logic [7:0]  rin, rout;
  outs_t       w_act;

  int checks = 0;
  int errors = 0;
  int n_irin = 0;
  int n_done = 0;
  outs_t exp_q[$];
  outs_t hist[$];
  outs_t cur_exp;
  logic  ok_bus, ok_rin, ok_rout;

  cpu_ctrl_fsm #(.DATA_WIDTH(16), .NUM_REGS(8), .IR_WIDTH(9)) dut (
    .clk(clk), .resetn(resetn), .run(run), .din(din), .g_nz(g_nz),
    .irin(irin), .rin(rin), .rout(rout), .gout(gout), .dinout(dinout),
    .ain(ain), .gin(gin), .sub(sub), .done(done)
  );

  assign w_act = {irin, rin, rout, gout, dinout, ain, gin, sub, done};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] oh(input logic [2:0] n);
    logic [7:0] one = 8'h01;
    return one << n;
  endfunction

  // Instruction-level model: expected outputs for slot k (0 = T1) after fetch.
  function automatic int nslots(input logic [8:0] ins);
    return (ins[8:6] == 3'd2 || ins[8:6] == 3'd3) ? 3 : 1;
  endfunction

  function automatic outs_t slot(input logic [8:0] ins, input logic gn, input int k);
    outs_t o = '0;
    logic [2:0] op = ins[8:6];
    logic [2:0] x  = ins[5:3];
    logic [2:0] y  = ins[2:0];
    case (op)
      3'd0: begin o.rout = oh(y); o.rin = oh(x); o.done = 1'b1; end
      3'd1: begin o.dinout = 1'b1; o.rin = oh(x); o.done = 1'b1; end
      3'd2, 3'd3: begin
        if (k == 0) begin o.rout = oh(x); o.ain = 1'b1; end
        else if (k == 1) begin o.rout = oh(y); o.gin = 1'b1; o.sub = (op == 3'd3); end
        else begin o.gout = 1'b1; o.rin = oh(x); o.done = 1'b1; end
      end
`ifdef CPU_CTRL_MVNZ_EN
      3'd4: begin
        if (gn) begin o.rout = oh(y); o.rin = oh(x); end
        o.done = 1'b1;
      end
`endif
      default: o.done = 1'b1;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    hist.push_back(w_act);
    if (irin) n_irin++;
    if (done) n_done++;
    if (exp_q.size() > 0) begin
      cur_exp = exp_q.pop_front();
      chk("cycle_outputs", 32'(w_act), 32'(cur_exp));
    end
    if (resetn) begin
      ok_bus  = $countones({rout, gout, dinout}) <= 1;
      ok_rin  = $countones(rin) <= 1;
      ok_rout = $countones(rout) <= 1;
      chk("bus_exclusive", 32'(ok_bus), 32'd1);
      chk("rin_onehot0", 32'(ok_rin), 32'd1);
      chk("rout_onehot0", 32'(ok_rout), 32'd1);
    end
  end

  task automatic cyc(input logic r, input logic [15:0] d, input logic gn, input outs_t e);
    run  = r;
    din  = d;
    g_nz = gn;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [8:0] ins, input logic gn, input logic [15:0] imm,
                       input logic rnd_run);
    outs_t      t0 = '0;
    logic [15:0] d;
    logic        r;
    t0.irin = 1'b1;
    d = 16'($urandom);
    d[8:0] = ins;
    cyc(1'b1, d, gn, t0);
    for (int k = 0; k < nslots(ins); k++) begin
      d = (k == 0 && ins[8:6] == 3'd1) ? imm : 16'($urandom);
      r = rnd_run ? 1'($urandom) : 1'b0;
      cyc(r, d, gn, slot(ins, gn, k));
    end
  endtask

  task automatic idle();
    cyc(1'b0, 16'($urandom), 1'($urandom), '0);
  endtask

  initial begin
    int b;
    int i0, d0;
    logic [8:0] ins;
    resetn = 1'b0;
    run    = 1'b0;
    din    = '0;
    g_nz   = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_irin", 32'(irin), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    repeat (3) idle();
    resetn = 1'b1;
    repeat (2) idle();

    // mvi R0,#00A5 then mv R3,R0 back to back
    b = hist.size();
    issue(9'o100, 1'b0, 16'h00A5, 1'b0);
    issue(9'o030, 1'b0, 16'h0000, 1'b0);
    chk("mvi_dinout", 32'(hist[b+1].dinout), 32'd1);
    chk("mvi_rin", 32'(hist[b+1].rin), 32'h01);
    chk("mvi_done", 32'(hist[b+1].done), 32'd1);
    chk("mv_b2b_irin", 32'(hist[b+2].irin), 32'd1);
    chk("mv_rout", 32'(hist[b+3].rout), 32'h01);
    chk("mv_rin", 32'(hist[b+3].rin), 32'h08);

    // add R1,R2
    b = hist.size();
    issue(9'o212, 1'b0, 16'h0, 1'b1);
    idle();
    chk("add_t1_rout", 32'(hist[b+1].rout), 32'h02);
    chk("add_t1_ain", 32'(hist[b+1].ain), 32'd1);
    chk("add_t2_rout", 32'(hist[b+2].rout), 32'h04);
    chk("add_t2_gin", 32'(hist[b+2].gin), 32'd1);
    chk("add_t2_sub", 32'(hist[b+2].sub), 32'd0);
    chk("add_t3_gout", 32'(hist[b+3].gout), 32'd1);
    chk("add_t3_rin", 32'(hist[b+3].rin), 32'h02);
    chk("add_t3_done", 32'(hist[b+3].done), 32'd1);
    chk("add_t2_done", 32'(hist[b+2].done), 32'd0);

    // sub R5,R6 followed immediately by another fetch
    b = hist.size();
    issue(9'o356, 1'b0, 16'h0, 1'b1);
    issue(9'o555, 1'b0, 16'h0, 1'b0);
    chk("sub_t2_sub", 32'(hist[b+2].sub), 32'd1);
    chk("sub_t2_rout", 32'(hist[b+2].rout), 32'h40);
    chk("sub_t3_rin", 32'(hist[b+3].rin), 32'h20);
    chk("sub_t3_done", 32'(hist[b+3].done), 32'd1);
    chk("sub_b2b_irin", 32'(hist[b+4].irin), 32'd1);
    chk("nop_done", 32'(hist[b+5].done), 32'd1);
    chk("nop_rin", 32'(hist[b+5].rin), 32'h00);

    // mvnz R4,R7 with g_nz low then high
    b = hist.size();
    issue(9'o447, 1'b0, 16'h0, 1'b0);
    issue(9'o447, 1'b1, 16'h0, 1'b0);
    chk("mvnz0_rin", 32'(hist[b+1].rin), 32'h00);
    chk("mvnz0_done", 32'(hist[b+1].done), 32'd1);
`ifdef CPU_CTRL_MVNZ_EN
    chk("mvnz1_rout", 32'(hist[b+3].rout), 32'h80);
    chk("mvnz1_rin", 32'(hist[b+3].rin), 32'h10);
`else
    chk("mvnz1_rout", 32'(hist[b+3].rout), 32'h00);
    chk("mvnz1_rin", 32'(hist[b+3].rin), 32'h00);
`endif

    // X = Y cases
    b = hist.size();
    issue(9'o033, 1'b0, 16'h0, 1'b0);
    issue(9'o222, 1'b0, 16'h0, 1'b0);
    chk("mv33_rout", 32'(hist[b+1].rout), 32'h08);
    chk("mv33_rin", 32'(hist[b+1].rin), 32'h08);
    chk("add22_t2_rout", 32'(hist[b+4].rout), 32'h04);
    chk("add22_t3_rin", 32'(hist[b+5].rin), 32'h04);

    // Reset during T2 of add R1,R2: strobes must drop without a clock edge
    cyc(1'b1, 16'o212, 1'b0, 8'h0 == 8'h0 ? outs_t'({1'b1, 22'h0}) : '0);
    cyc(1'b0, 16'h0, 1'b0, slot(9'o212, 1'b0, 0));
    run = 1'b0;
    #1;
    chk("abort_pre_gin", 32'(gin), 32'd1);
    chk("abort_pre_rout", 32'(rout), 32'h04);
    resetn = 1'b0;
    #1;
    chk("abort_outs", 32'(w_act), 32'd0);
    @(posedge clk);
    #1;
    repeat (2) idle();
    resetn = 1'b1;
    idle();
    chk("post_reset_outs", 32'(hist[hist.size()-1]), 32'd0);
    issue(9'o165, 1'b0, 16'h1234, 1'b0);

    // Random stream
    i0 = n_irin;
    d0 = n_done;
    for (int n = 0; n < 1000; n++) begin
      ins = 9'($urandom);
      issue(ins, 1'($urandom), 16'($urandom), 1'b1);
      if ($urandom_range(0, 7) == 0) idle();
    end
    chk("done_eq_irin", 32'(n_done - d0), 32'(n_irin - i0));
    chk("irin_count", 32'(n_irin - i0), 32'd1000);
    repeat (2) idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
